conv1d_obi_mgr: RTL and testbench

CONV1D_OBI_MGR -- requirements
Module: conv1d_obi_mgr

---
 rtl/conv1d_obi_mgr.sv | 166 ++++++++++++++++
 tb/tb_conv1d_obi_mgr.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_obi_mgr.sv
// conv1d_obi_mgr: read-only OBI manager that streams a block
// of 32-bit words from memory into the conv1d datapath.
module conv1d_obi_mgr #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             obi_req_o,
  output logic [31:0]      obi_addr_o,
  output logic             obi_we_o,
  output logic [3:0]       obi_be_o,
  output logic [31:0]      obi_wdata_o,
  input  logic             obi_gnt_i,
  input  logic             obi_rvalid_i,
  input  logic [31:0]      obi_rdata_i,
  input  logic             obi_err_i,
  output logic [31:0]      data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      addr_q;
  logic [LEN_W-1:0] req_left_q;
  logic [LEN_W-1:0] rsp_left_q;
  logic [CW-1:0]    outst_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [31:0]      mem [DEPTH];
  logic             pend_q;
  logic             err_q;
  logic             done_q;

  logic             start_ok;
  logic             launch;
  logic             credit_ok;
  logic [CW:0]      used;
  logic             gnt;
  logic             rx;
  logic             last_gnt;
  logic             last_rsp;
  logic             pop;
  logic             unused_base;

  assign unused_base = ^base_addr_i[1:0];

  assign obi_we_o    = 1'b0;
  assign obi_be_o    = 4'hF;
  assign obi_wdata_o = '0;

  assign start_ok = start_i && (state_q == IDLE);
  assign launch   = start_ok && (len_i != '0);

  // A request already on the bus stays up until granted,
  // even if credits have dropped in the meantime.
  assign used      = {1'b0, outst_q} + {1'b0, cnt_q};
  assign credit_ok = used < (CW+1)'(DEPTH);
  assign obi_req_o = (state_q == FETCH) && (pend_q || credit_ok);
  assign obi_addr_o = addr_q;

  // Stray responses outside a transfer (e.g. after a reset
  // abandoned one) are dropped rather than queued.
  assign gnt      = obi_req_o && obi_gnt_i;
  assign rx       = obi_rvalid_i && (state_q != IDLE);
  assign last_gnt = gnt && (req_left_q == LEN_W'(1));
  assign last_rsp = rx && (rsp_left_q == LEN_W'(1));

  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem[rptr_q] : '0;
  assign pop     = valid_o && ready_i;

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

  // Next-state decode for the fetch sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = FETCH;
      FETCH:   if (last_gnt) state_d = DRAIN;
      DRAIN:   if (last_rsp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer, address, counters, FIFO pointers and flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      req_left_q <= '0;
      rsp_left_q <= '0;
      outst_q    <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= obi_req_o && !obi_gnt_i;
      done_q  <= last_rsp || (start_ok && (len_i == '0));

      if (launch) begin
        addr_q     <= {base_addr_i[31:2], 2'b00};
        req_left_q <= len_i;
        rsp_left_q <= len_i;
      end else begin
        if (gnt) begin
          addr_q     <= addr_q + 32'd4;
          req_left_q <= req_left_q - LEN_W'(1);
        end
        if (rx) begin
          rsp_left_q <= rsp_left_q - LEN_W'(1);
        end
      end

      unique case ({gnt, rx})
        2'b10:   outst_q <= outst_q + CW'(1);
        2'b01:   outst_q <= outst_q - CW'(1);
        default: outst_q <= outst_q;
      endcase

      unique case ({rx, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase

      if (rx)  wptr_q <= wptr_q + PW'(1);
      if (pop) rptr_q <= rptr_q + PW'(1);

      if (start_ok) begin
        err_q <= 1'b0;
      end else if (rx && obi_err_i) begin
        err_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (rx) mem[wptr_q] <= obi_rdata_i;
  end

endmodule

// File: tb/tb_conv1d_obi_mgr.sv
// tb_conv1d_obi_mgr: random OBI subordinate and consumer
// checked against a transfer-level reference model.
module tb_conv1d_obi_mgr;

  localparam int DEPTH = 4;
  localparam int LEN_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [31:0]      base_addr_i;
  logic [LEN_W-1:0] len_i;
  logic             obi_req_o;
  logic [31:0]      obi_addr_o;
  logic             obi_we_o;
  logic [3:0]       obi_be_o;
  logic [31:0]      obi_wdata_o;
  logic             obi_gnt_i;
  logic             obi_rvalid_i;
  logic [31:0]      obi_rdata_i;
  logic             obi_err_i;
  logic [31:0]      data_o;
  logic             valid_o;
  logic             ready_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  conv1d_obi_mgr #(
    .DEPTH(DEPTH),
    .LEN_W(LEN_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .obi_req_o   (obi_req_o),
    .obi_addr_o  (obi_addr_o),
    .obi_we_o    (obi_we_o),
    .obi_be_o    (obi_be_o),
    .obi_wdata_o (obi_wdata_o),
    .obi_gnt_i   (obi_gnt_i),
    .obi_rvalid_i(obi_rvalid_i),
    .obi_rdata_i (obi_rdata_i),
    .obi_err_i   (obi_err_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          granted, rcvd, popped, done_at;
  logic        exp_err;
  logic [31:0] exp_addr;
  logic        prev_pend, prev_stall;
  logic [31:0] prev_data;

  task automatic run_xfer(input logic [31:0] base,
                          input int len,
                          input int gnt_pct,
                          input int rdy_pct,
                          input int lat_max,
                          input int err_pct,
                          input int err_idx,
                          input int gnt_hold,
                          input int rdy_hold);
    logic [31:0] a;
    int          rb;
    bit          fin;
    @(negedge clk_i);
    start_i      = 1'b1;
    base_addr_i  = base;
    len_i        = LEN_W'(len);
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b0;
    obi_err_i    = 1'b0;
    ready_i      = 1'b0;
    a = {base[31:2], 2'b00};
    exp_addr = a;
    exp_q.delete();
    pend_addr.delete();
    pend_due.delete();
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(mem_word(a));
      a = a + 32'd4;
    end
    granted = 0; rcvd = 0; popped = 0;
    exp_err = 1'b0;
    done_at = (len == 0) ? cyc + 1 : -1;
    prev_pend = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    fin = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_i);
      cyc++;
      start_i = 1'b0;
      rb = rcvd;
      chk("done", 32'(done_o), 32'(cyc == done_at));
      chk("busy", 32'(busy_o), 32'(rcvd < len));
      chk("err", 32'(err_o), 32'(exp_err));
      chk("valid", 32'(valid_o), 32'(rcvd > popped));
      if (granted == len) begin
        chk("no_req", 32'(obi_req_o), 0);
      end else begin
        if (prev_pend) chk("req_hold", 32'(obi_req_o), 1);
        if (obi_req_o) chk("addr", obi_addr_o, exp_addr);
        if (obi_req_o && !prev_pend)
          chk("credit", 32'(granted - popped < DEPTH), 1);
      end
      if (rdy_hold > 0 && n == rdy_hold)
        chk("credit_stall", 32'(granted),
            32'((len < DEPTH) ? len : DEPTH));
      if (prev_stall) chk("data_hold", data_o, prev_data);
      if (rcvd == len && popped == len && done_at >= 0 &&
          cyc > done_at) begin
        fin = 1'b1;
        break;
      end
      ready_i = (n >= rdy_hold) && ($urandom_range(99) < rdy_pct);
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else chk("data", data_o, exp_q.pop_front());
        popped++;
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      obi_rvalid_i = 1'b0;
      obi_err_i    = 1'b0;
      obi_rdata_i  = $urandom;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
        obi_err_i = (rcvd == err_idx) ||
                    ($urandom_range(99) < err_pct);
        exp_err = exp_err | obi_err_i;
        rcvd++;
        if (rcvd == len) done_at = cyc + 1;
      end
      obi_gnt_i = (n >= gnt_hold) && ($urandom_range(99) < gnt_pct);
      prev_pend = obi_req_o && !obi_gnt_i;
      if (obi_req_o && obi_gnt_i) begin
        pend_addr.push_back(exp_addr);
        pend_due.push_back(cyc + 1 + int'($urandom_range(lat_max)));
        exp_addr = exp_addr + 32'd4;
        granted++;
      end
      if (rb < len && $urandom_range(7) == 0) begin
        start_i     = 1'b1;
        base_addr_i = $urandom;
        len_i       = LEN_W'($urandom);
      end
    end
    start_i      = 1'b0;
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b0;
    obi_err_i    = 1'b0;
    ready_i      = 1'b0;
    if (!fin) chk("timeout", 0, 1);
  endtask

  task automatic chk_reset_outs();
    chk("rst_req", 32'(obi_req_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_addr", obi_addr_o, 0);
    chk("rst_data", data_o, 0);
  endtask

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    base_addr_i  = '0;
    len_i        = '0;
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b0;
    obi_rdata_i  = '0;
    obi_err_i    = 1'b0;
    ready_i      = 1'b0;
    #1;
    chk_reset_outs();
    chk("we", 32'(obi_we_o), 0);
    chk("be", 32'(obi_be_o), 32'hF);
    chk("wdata", obi_wdata_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    run_xfer(32'h0000_1000, 3, 100, 100, 0, 0, -1, 0, 0);
    run_xfer(32'h0000_4000, 8, 100, 100, 0, 0, -1, 0, 20);
    run_xfer(32'h0000_3000, 4, 100, 100, 0, 0, -1, 5, 0);
    run_xfer(32'h0000_5000, 0, 100, 100, 0, 0, -1, 0, 0);
    run_xfer(32'hFFFF_FFFC, 2, 100, 100, 0, 0, 1, 0, 0);
    repeat (3) @(negedge clk_i);
    chk("err_sticky", 32'(err_o), 1);

    @(negedge clk_i);
    start_i     = 1'b1;
    base_addr_i = 32'h0000_2000;
    len_i       = LEN_W'(8);
    obi_gnt_i   = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    obi_gnt_i = 1'b0;
    chk("pre_rst_addr", obi_addr_o, 32'h0000_2008);
    chk("pre_rst_busy", 32'(busy_o), 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk_reset_outs();
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      chk("post_rst_req", 32'(obi_req_o), 0);
    end
    run_xfer(32'h0000_2000, 5, 100, 100, 1, 0, -1, 0, 0);

    for (int t = 0; t < 25; t++) begin
      run_xfer($urandom, int'($urandom_range(20)),
               int'($urandom_range(100, 30)),
               int'($urandom_range(100, 30)),
               int'($urandom_range(4)),
               int'($urandom_range(10)), -1, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
